// File: rtl/seg7_scan_mux_if.sv
// Scan-mux port bundle: host-side digit data in, multiplexed LED drive out.
// The slave modport is the driver's view; master is the host/bench view.
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame;

  modport master (
    output en, load, value, dp, blank,
    input  seg, dp_n, an, frame
  );

  modport slave (
    input  en, load, value, dp, blank,
    output seg, dp_n, an, frame
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver; all outputs registered one clock after scan state, load is a
// fire-and-forget strobe with no backpressure. Define SEG7_LZS_EN to enable leading-zero suppression.
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_mux_if.slave  bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shd_val_q, shd_val_d, pnd_val_q, pnd_val_d;
  logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d, pnd_dp_q, pnd_dp_d;
  logic [NUM_DIGITS-1:0] shd_blank_q, shd_blank_d, pnd_blank_q, pnd_blank_d;
  logic                  pend_q, pend_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;
  logic                  tick, wrap;
  logic [3:0]            cur_nib;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign tick    = bus.en && (cnt_q == CNT_MAX);
  assign wrap    = tick && (idx_q == IDX_MAX);
  assign cur_nib = shd_val_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LZS_EN
  // A digit goes dark when it and every digit to its left hold zero, unless its dp is lit.
  logic [NUM_DIGITS-1:0] lz_sup;
  always_comb begin
    logic zeros_above;
    zeros_above = 1'b1;
    lz_sup      = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zeros_above = zeros_above && (shd_val_q[4*k +: 4] == 4'h0);
      lz_sup[k]   = zeros_above && !shd_dp_q[k];
    end
  end
`endif

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shd_val_d   = shd_val_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    pnd_val_d   = pnd_val_q;
    pnd_dp_d    = pnd_dp_q;
    pnd_blank_d = pnd_blank_q;
    pend_d      = pend_q;
    an_d        = '1;
    seg_d       = 7'h7F;
    dp_n_d      = 1'b1;
    frame_d     = wrap;

    if (bus.en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      if (cnt_q >= CNT_DEAD) begin
        an_d = ~(NUM_DIGITS'(1) << idx_q);
      end
      if (!shd_blank_q[idx_q]) begin
        dp_n_d = ~shd_dp_q[idx_q];
`ifdef SEG7_LZS_EN
        seg_d  = lz_sup[idx_q] ? 7'h7F : glyph(cur_nib);
`else
        seg_d  = glyph(cur_nib);
`endif
      end
    end

    // Shadow only changes on the frame wrap; a coincident load bypasses the pending buffer.
    if (wrap) begin
      pend_d = 1'b0;
      if (bus.load) begin
        shd_val_d   = bus.value;
        shd_dp_d    = bus.dp;
        shd_blank_d = bus.blank;
      end else if (pend_q) begin
        shd_val_d   = pnd_val_q;
        shd_dp_d    = pnd_dp_q;
        shd_blank_d = pnd_blank_q;
      end
    end else if (bus.load) begin
      pnd_val_d   = bus.value;
      pnd_dp_d    = bus.dp;
      pnd_blank_d = bus.blank;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shd_val_q   <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '0;
      pnd_val_q   <= '0;
      pnd_dp_q    <= '0;
      pnd_blank_q <= '0;
      pend_q      <= 1'b0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dp_n_q      <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shd_val_q   <= shd_val_d;
      shd_dp_q    <= shd_dp_d;
      shd_blank_q <= shd_blank_d;
      pnd_val_q   <= pnd_val_d;
      pnd_dp_q    <= pnd_dp_d;
      pnd_blank_q <= pnd_blank_d;
      pend_q      <= pend_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp_n  = dp_n_q;
  assign bus.an    = an_q;
  assign bus.frame = frame_q;
endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clocks per digit slot; legal range DEAD_CYC+2 .. 2^20.
REQ-003 Parameter DEAD_CYC, default 2: clocks at the start of each slot with all anodes off (anti-ghosting); legal range 0..SCAN_DIV-2.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  scan enable; 0 freezes the scan and darkens the display.
REQ-007 load  input  1  one-cycle strobe; captures value, dp and blank into the pending buffer.
REQ-008 value  input  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is rightmost.
REQ-009 dp  input  NUM_DIGITS  decimal point request per digit, active-high.
REQ-010 blank  input  NUM_DIGITS  forced blank per digit, active-high.
REQ-011 seg  output  7  segments, active-low, bit0=a .. bit6=g, registered.
REQ-012 dp_n  output  1  decimal point, active-low, registered.
REQ-013 an  output  NUM_DIGITS  digit anodes, active-low, one-hot-low or all-high, registered.
REQ-014 frame  output  1  one-cycle pulse on each frame wrap, registered.

Function
REQ-015 The prescaler cnt SHALL count 0..SCAN_DIV-1 while en=1; tick = (cnt==SCAN_DIV-1); cnt returns to 0 on tick.
REQ-016 On tick, digit index idx SHALL increment; NUM_DIGITS-1 wraps to 0 (wrap tick).
REQ-017 With en=0, cnt and idx SHALL hold; on the next edge an=all 1, seg=7'h7F, dp_n=1 and frame=0; with en=1 again, the scan resumes from the held cnt/idx.
REQ-018 Glyph table SHALL be the active-low hex set: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (bit6..bit0).
REQ-019 Outputs SHALL reflect the current idx/cnt with exactly one clock of latency.
REQ-020 When cnt<DEAD_CYC, an SHALL be all 1; otherwise an[idx]=0 and all other bits 1.
REQ-021 seg SHALL be the glyph of shadow nibble idx; dp_n SHALL be ~shadow_dp[idx].
REQ-022 If shadow_blank[idx]=1, seg SHALL be 7'h7F and dp_n SHALL be 1; the anode still follows REQ-020.
REQ-023 load SHALL write value/dp/blank into the pending buffer and set pend; a later load before transfer overwrites pending.
REQ-024 On a wrap tick with pend=1, the shadow SHALL take the pending contents and pend SHALL clear; the display never changes mid-frame.
REQ-025 If load coincides with a wrap tick, the data presented in that cycle SHALL go directly to the shadow and pend SHALL end at 0.
REQ-026 frame SHALL pulse high for one clock, one cycle after each wrap tick.
REQ-027 NUM_DIGITS=1 SHALL make every tick a wrap tick; an is 1 bit.

Reset
REQ-028 While rst_n=0, and immediately when it falls (including mid-slot), the block SHALL force cnt=0, idx=0, shadow/pending value/dp/blank=0, pend=0, an=all 1, seg=7'h7F, dp_n=1, frame=0.
REQ-029 After rst_n rises, the first active slot SHALL be digit 0 and SHALL show glyph 0.

Configuration
REQ-030 With macro SEG7_LZS_EN defined, leading-zero suppression SHALL apply. Digit k>0 displays as blank (seg=7'h7F) when nibbles k..NUM_DIGITS-1 of the shadow are all 0. Exception: shadow_dp[k]=1 keeps the digit visible. Digit 0 is never suppressed.
REQ-031 Without SEG7_LZS_EN, zeros SHALL display as glyph 0; no suppression logic is present.

Verification
REQ-032 NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYC=1; load value=16'h12AF -> after the next frame, slots show an=1110/seg=0001110, an=1101/seg=0001000, an=1011/seg=0100100, an=0111/seg=1111001. Each slot has 1 dead cycle with an=1111, and frame pulses every 16 clocks.
REQ-033 Mid-frame load 16'h1234, then load 16'h5678 two cycles later -> the display keeps the old data until the wrap. The next frame shows 5678; 1234 never appears.
REQ-034 Load value=16'h0042, dp=0 -> with SEG7_LZS_EN, digits 3 and 2 show 1111111. Without the macro, they show 1000000. With dp=4'b0100 and the macro, digit 2 shows 1000000 and dp_n=0.
REQ-035 blank=4'b0010 with value=16'h8888 -> digit 1 shows seg=1111111, dp_n=1, and its anode is still asserted; other digits show 0000000.
REQ-036 en=0 for 10 clocks mid-slot on digit 2 -> an=1111 and seg=1111111 from the next edge. After en=1, digit 2 resumes and its slot completes with the remaining count.
REQ-037 Assert rst_n=0 asynchronously mid-slot with pend=1 -> an=all 1 and seg=7'h7F without a clock edge. After release, digit 0 shows 1000000 and the pending data is discarded.
